// File: rtl/eye_box_measure.sv
// eye_box_measure
// Per-frame eye bounding-box measurement. Watches the binarized pixel stream,
// tracks min/max x/y of dark pixels inside an eye ROI (shadowed at start of
// frame) and publishes height/width one clock after the last pixel of a
// frame, or zeros when fewer than MIN_PIX dark ROI pixels were seen.
// Optional feature macro: EYE_BOX_AVG_EN -- outputs become the average of the
// current and previous frame's raw height/width.
module eye_box_measure #(
    parameter int H_ACT   = 800,
    parameter int V_ACT   = 480,
    parameter int MIN_PIX = 16
) (
    input  logic        module_clk,
    input  logic        module_rst_n,
    input  logic        pixel_en,
    input  logic [10:0] lcd_pixel_xpos,
    input  logic [10:0] lcd_pixel_ypos,
    input  logic        pixel_dark,
    input  logic [10:0] roi_x_start,
    input  logic [10:0] roi_x_end,
    input  logic [10:0] roi_y_start,
    input  logic [10:0] roi_y_end,
    output logic [10:0] eye_high,
    output logic [10:0] eye_wide,
    output logic        eye_found,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic [10:0] X_LAST    = 11'(H_ACT - 1);
    localparam logic [10:0] Y_LAST    = 11'(V_ACT - 1);
    localparam logic [15:0] MIN_CNT   = 16'(MIN_PIX);
    localparam logic [10:0] COORD_MAX = 11'd2047;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    state_t      state, state_n;
    logic        sof, eof;
    logic        restart;
    logic        load_out;
    logic        hit;

    logic [10:0] roi_xs_q, roi_xe_q, roi_ys_q, roi_ye_q;
    logic [10:0] roi_xs_n, roi_xe_n, roi_ys_n, roi_ye_n;
    logic [10:0] xmin_q, xmax_q, ymin_q, ymax_q;
    logic [10:0] xmin_n, xmax_n, ymin_n, ymax_n;
    logic [15:0] count_q, count_n;

    logic        found;
    logic [10:0] raw_high, raw_wide;

`ifdef EYE_BOX_AVG_EN
    logic [10:0] prev_high, prev_wide;
    logic [11:0] sum_high, sum_wide;
`endif

    assign sof = pixel_en && (lcd_pixel_xpos == 11'd0) && (lcd_pixel_ypos == 11'd0);
    assign eof = pixel_en && (lcd_pixel_xpos == X_LAST) && (lcd_pixel_ypos == Y_LAST);

    // Frame-phase state register
    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
            state <= state_n;
        end
    end

    // Next-state decode: start/restart on SOF, latch after EOF
    always_comb begin
        // NOTE: each combinational output gets a default first, so no path can infer a latch.
        state_n  = state;
        restart  = 1'b0;
        load_out = 1'b0;
        unique case (state)
            IDLE: begin
                if (sof) begin
                    restart = 1'b1;
                    state_n = ACCUM;
                end
            end
            ACCUM: begin
                if (sof) begin
                    restart = 1'b1;
                end else if (eof) begin
                    state_n = LATCH;
                end
            end
            LATCH: begin
                load_out = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Accumulator update: the SOF pixel is judged against the ROI being shadowed
    always_comb begin
        // NOTE: blocking assignments here let later statements build on earlier partial results.
        roi_xs_n = restart ? roi_x_start : roi_xs_q;
        roi_xe_n = restart ? roi_x_end   : roi_xe_q;
        roi_ys_n = restart ? roi_y_start : roi_ys_q;
        roi_ye_n = restart ? roi_y_end   : roi_ye_q;

        if (restart) begin
            xmin_n  = COORD_MAX;
            xmax_n  = '0;
            ymin_n  = COORD_MAX;
            ymax_n  = '0;
            count_n = '0;
        end else begin
            xmin_n  = xmin_q;
            xmax_n  = xmax_q;
            ymin_n  = ymin_q;
            ymax_n  = ymax_q;
            count_n = count_q;
        end

        hit = pixel_en && pixel_dark && (restart || (state == ACCUM)) &&
              (lcd_pixel_xpos >= roi_xs_n) && (lcd_pixel_xpos <= roi_xe_n) &&
              (lcd_pixel_ypos >= roi_ys_n) && (lcd_pixel_ypos <= roi_ye_n);

        if (hit) begin
            if (lcd_pixel_xpos < xmin_n) xmin_n = lcd_pixel_xpos;
            if (lcd_pixel_xpos > xmax_n) xmax_n = lcd_pixel_xpos;
            if (lcd_pixel_ypos < ymin_n) ymin_n = lcd_pixel_ypos;
            if (lcd_pixel_ypos > ymax_n) ymax_n = lcd_pixel_ypos;
            if (count_n != CNT_MAX) count_n = count_n + 16'd1;
        end
    end

    // ROI shadow and bounding-box accumulators
    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            roi_xs_q <= '0;
            roi_xe_q <= '0;
            roi_ys_q <= '0;
            roi_ye_q <= '0;
            xmin_q   <= COORD_MAX;
            xmax_q   <= '0;
            ymin_q   <= COORD_MAX;
            ymax_q   <= '0;
            count_q  <= '0;
        end else begin
            roi_xs_q <= roi_xs_n;
            roi_xe_q <= roi_xe_n;
            roi_ys_q <= roi_ys_n;
            roi_ye_q <= roi_ye_n;
            xmin_q   <= xmin_n;
            xmax_q   <= xmax_n;
            ymin_q   <= ymin_n;
            ymax_q   <= ymax_n;
            count_q  <= count_n;
        end
    end

    // Raw frame measurement from the finished accumulators
    always_comb begin
        found    = (count_q >= MIN_CNT);
        raw_high = '0;
        raw_wide = '0;
        if (found) begin
            raw_high = ymax_q - ymin_q + 11'd1;
            raw_wide = xmax_q - xmin_q + 11'd1;
        end
    end

`ifdef EYE_BOX_AVG_EN
    assign sum_high = {1'b0, raw_high} + {1'b0, prev_high};
    assign sum_wide = {1'b0, raw_wide} + {1'b0, prev_wide};
`endif

    // Published outputs, updated only in the LATCH cycle
    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            eye_high   <= '0;
            eye_wide   <= '0;
            eye_found  <= 1'b0;
            frame_done <= 1'b0;
`ifdef EYE_BOX_AVG_EN
            prev_high  <= '0;
            prev_wide  <= '0;
`endif
        end else begin
            frame_done <= load_out;
            if (load_out) begin
                eye_found <= found;
`ifdef EYE_BOX_AVG_EN
                eye_high  <= 11'(sum_high >> 1);
                eye_wide  <= 11'(sum_wide >> 1);
                prev_high <= raw_high;
                prev_wide <= raw_wide;
`else
                eye_high  <= raw_high;
                eye_wide  <= raw_wide;
`endif
            end
        end
    end

endmodule

// File: tb/tb_eye_box_measure.sv
// tb_eye_box_measure
// Self-checking bench for eye_box_measure: directed frames with hand-computed
// results plus randomized frames, all compared each cycle against a
// frame-level reference model (pixel list per frame, bounding box computed at
// EOF). Honours EYE_BOX_AVG_EN when defined.
module tb_eye_box_measure;

    localparam int H_ACT   = 800;
    localparam int V_ACT   = 480;
    localparam int MIN_PIX = 16;

    logic        module_clk;
    logic        module_rst_n;
    logic        pixel_en;
    logic [10:0] lcd_pixel_xpos;
    logic [10:0] lcd_pixel_ypos;
    logic        pixel_dark;
    logic [10:0] roi_x_start, roi_x_end, roi_y_start, roi_y_end;
    logic [10:0] eye_high, eye_wide;
    logic        eye_found, frame_done;

    eye_box_measure #(
        .H_ACT  (H_ACT),
        .V_ACT  (V_ACT),
        .MIN_PIX(MIN_PIX)
    ) dut (
        .module_clk    (module_clk),
        .module_rst_n  (module_rst_n),
        .pixel_en      (pixel_en),
        .lcd_pixel_xpos(lcd_pixel_xpos),
        .lcd_pixel_ypos(lcd_pixel_ypos),
        .pixel_dark    (pixel_dark),
        .roi_x_start   (roi_x_start),
        .roi_x_end     (roi_x_end),
        .roi_y_start   (roi_y_start),
        .roi_y_end     (roi_y_end),
        .eye_high      (eye_high),
        .eye_wide      (eye_wide),
        .eye_found     (eye_found),
        .frame_done    (frame_done)
    );

    initial module_clk = 1'b0;
    always #5 module_clk = ~module_clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int x;
        int y;
        bit dark;
    } pix_t;

    pix_t frame_q[$];
    bit   in_frame   = 1'b0;
    bit   latch_pend = 1'b0;
    int   rxs, rxe, rys, rye;
    int   exp_high   = 0;
    int   exp_wide   = 0;
    bit   exp_found  = 1'b0;
    bit   exp_done   = 1'b0;
    int   prev_h     = 0;
    int   prev_w     = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    function automatic void model_reset();
        frame_q.delete();
        in_frame   = 1'b0;
        latch_pend = 1'b0;
        exp_high   = 0;
        exp_wide   = 0;
        exp_found  = 1'b0;
        exp_done   = 1'b0;
        prev_h     = 0;
        prev_w     = 0;
    endfunction

    // Bounding box of all dark pixels of the frame that lie inside the ROI captured at SOF
    function automatic void publish();
        int cnt = 0;
        int xmn = 2047, xmx = 0, ymn = 2047, ymx = 0;
        int rh = 0, rw = 0;
        foreach (frame_q[i]) begin
            if (frame_q[i].dark && frame_q[i].x >= rxs && frame_q[i].x <= rxe &&
                frame_q[i].y >= rys && frame_q[i].y <= rye) begin
                cnt++;
                if (frame_q[i].x < xmn) xmn = frame_q[i].x;
                if (frame_q[i].x > xmx) xmx = frame_q[i].x;
                if (frame_q[i].y < ymn) ymn = frame_q[i].y;
                if (frame_q[i].y > ymx) ymx = frame_q[i].y;
            end
        end
        exp_found = (cnt >= MIN_PIX);
        if (exp_found) begin
            rh = ymx - ymn + 1;
            rw = xmx - xmn + 1;
        end
`ifdef EYE_BOX_AVG_EN
        exp_high = (rh + prev_h) >> 1;
        exp_wide = (rw + prev_w) >> 1;
        prev_h   = rh;
        prev_w   = rw;
`else
        exp_high = rh;
        exp_wide = rw;
`endif
    endfunction

    // Advance the model by one clock using the inputs that were just sampled
    function automatic void model_clock();
        int x, y;
        exp_done = 1'b0;
        if (!module_rst_n) return;
        x = int'(lcd_pixel_xpos);
        y = int'(lcd_pixel_ypos);
        if (latch_pend) begin
            latch_pend = 1'b0;
            publish();
            exp_done = 1'b1;
        end else if (pixel_en) begin
            if (x == 0 && y == 0) begin
                in_frame = 1'b1;
                rxs = int'(roi_x_start);
                rxe = int'(roi_x_end);
                rys = int'(roi_y_start);
                rye = int'(roi_y_end);
                frame_q.delete();
                frame_q.push_back('{x, y, pixel_dark});
            end else if (in_frame) begin
                frame_q.push_back('{x, y, pixel_dark});
                if (x == H_ACT - 1 && y == V_ACT - 1) begin
                    in_frame   = 1'b0;
                    latch_pend = 1'b1;
                end
            end
        end
    endfunction

    // One compare process: every cycle, mid-way between active edges
    always @(negedge module_clk) begin
        check("eye_high",   32'(eye_high),   32'(exp_high));
        check("eye_wide",   32'(eye_wide),   32'(exp_wide));
        check("eye_found",  32'(eye_found),  32'(exp_found));
        check("frame_done", 32'(frame_done), 32'(exp_done));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit en, input int x, input int y, input bit dark);
        pixel_en       = en;
        lcd_pixel_xpos = 11'(x);
        lcd_pixel_ypos = 11'(y);
        pixel_dark     = dark;
        @(posedge module_clk);
        model_clock();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, $urandom_range(0, 799), $urandom_range(0, 479), 1'($urandom_range(0, 1)));
    endtask

    task automatic set_roi(input int xs, input int xe, input int ys, input int ye);
        roi_x_start = 11'(xs);
        roi_x_end   = 11'(xe);
        roi_y_start = 11'(ys);
        roi_y_end   = 11'(ye);
    endtask

    task automatic sof(input bit dark);
        step(1'b1, 0, 0, dark);
    endtask

    task automatic eof(input bit dark);
        step(1'b1, H_ACT - 1, V_ACT - 1, dark);
    endtask

    // Raster a window around a dark box; only pixels inside the box are dark
    task automatic scan_box(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0 - 2; y <= y1 + 2; y++)
            for (int x = x0 - 3; x <= x1 + 3; x++)
                step(1'b1, x, y, (x >= x0 && x <= x1 && y >= y0 && y <= y1));
    endtask

    task automatic do_reset();
        module_rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_high",  32'(eye_high),   32'd0);
        check("rst_wide",  32'(eye_wide),   32'd0);
        check("rst_found", 32'(eye_found),  32'd0);
        check("rst_done",  32'(frame_done), 32'd0);
        idle(2);
        module_rst_n = 1'b1;
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic rand_frame();
        int n, xs, xe, ys, ye, lo, span, x, y, t;
        n  = $urandom_range(0, 60);
        xs = $urandom_range(1, 700);
        ys = $urandom_range(0, 400);
        xe = xs + $urandom_range(0, 90);
        ye = ys + $urandom_range(0, 70);
        if ($urandom_range(0, 7) == 0) begin t = xs; xs = xe + 1; xe = t; end
        if ($urandom_range(0, 7) == 0) begin t = ys; ys = ye + 1; ye = t; end
        set_roi(xs, xe, ys, ye);
        sof(1'($urandom_range(0, 1)));
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            if ($urandom_range(0, 14) == 0)
                set_roi($urandom_range(0, 799), $urandom_range(0, 799),
                        $urandom_range(0, 479), $urandom_range(0, 479));
            if ($urandom_range(0, 3) != 0) begin
                lo   = (xs < xe) ? xs : xe;
                span = (xs < xe) ? xe - xs : xs - xe;
                x    = clampi(lo - 5 + $urandom_range(0, span + 10), 1, 798);
                lo   = (ys < ye) ? ys : ye;
                span = (ys < ye) ? ye - ys : ys - ye;
                y    = clampi(lo - 5 + $urandom_range(0, span + 10), 0, 478);
            end else begin
                x = $urandom_range(1, 798);
                y = $urandom_range(0, 478);
            end
            step(1'b1, x, y, ($urandom_range(0, 2) != 0));
        end
        if ($urandom_range(0, 3) == 0) idle(1);
        eof(1'($urandom_range(0, 1)));
        if ($urandom_range(0, 4) == 0) begin
            // zero blanking: this SOF lands in the latch cycle and its frame is skipped
            sof(1'b1);
            for (int i = 0; i < 4; i++)
                step(1'b1, $urandom_range(1, 798), $urandom_range(0, 478), 1'b1);
        end else begin
            idle($urandom_range(1, 3));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        module_rst_n = 1'b0;
        pixel_en = 1'b0;
        lcd_pixel_xpos = '0;
        lcd_pixel_ypos = '0;
        pixel_dark = 1'b0;
        set_roi(100, 199, 50, 99);
        model_reset();
        #3;
        check("por_high",  32'(eye_high),   32'd0);
        check("por_found", 32'(eye_found),  32'd0);
        check("por_done",  32'(frame_done), 32'd0);
        idle(2);
        module_rst_n = 1'b1;
        idle(2);

        // 40x20 dark rectangle, plus dark pixels outside the ROI
        sof(1'b0);
        scan_box(120, 159, 60, 79);
        step(1'b1, 300, 60, 1'b1);
        step(1'b1, 50, 70, 1'b1);
        step(1'b1, 150, 120, 1'b1);
        eof(1'b0);
        check("rect_done_early", 32'(frame_done), 32'd0);
        idle(1);
        check("rect_done", 32'(frame_done), 32'd1);
        check("rect_found", 32'(eye_found), 32'd1);
`ifdef EYE_BOX_AVG_EN
        check("rect_high", 32'(eye_high), 32'd10);
        check("rect_wide", 32'(eye_wide), 32'd20);
`else
        check("rect_high", 32'(eye_high), 32'd20);
        check("rect_wide", 32'(eye_wide), 32'd40);
`endif
        idle(1);
        check("rect_done_clr", 32'(frame_done), 32'd0);
        idle(3);

        // 31x11 rectangle
        sof(1'b0);
        scan_box(130, 160, 70, 80);
        eof(1'b0);
        idle(1);
`ifdef EYE_BOX_AVG_EN
        check("rect2_high", 32'(eye_high), 32'd15);
        check("rect2_wide", 32'(eye_wide), 32'd35);
`else
        check("rect2_high", 32'(eye_high), 32'd11);
        check("rect2_wide", 32'(eye_wide), 32'd31);
`endif
        idle(3);

        // Only 10 dark pixels in the ROI, many outside
        sof(1'b0);
        for (int x = 150; x < 160; x++) step(1'b1, x, 60, 1'b1);
        for (int x = 10; x <= 40; x++) step(1'b1, x, 10, 1'b1);
        for (int x = 150; x < 160; x++) step(1'b1, x, 120, 1'b1);
        eof(1'b1);
        idle(1);
        check("few_found", 32'(eye_found), 32'd0);
`ifndef EYE_BOX_AVG_EN
        check("few_high", 32'(eye_high), 32'd0);
        check("few_wide", 32'(eye_wide), 32'd0);
`endif
        idle(3);

        // ROI rewritten mid-frame: takes effect only from the next SOF
        for (int f = 0; f < 2; f++) begin
            sof(1'b0);
            for (int x = 110; x < 130; x++) step(1'b1, x, 55, 1'b1);
            set_roi(300, 399, 200, 249);
            for (int y = 210; y <= 211; y++)
                for (int x = 300; x < 330; x++) step(1'b1, x, y, 1'b1);
            eof(1'b0);
            idle(1);
            check("roi_found", 32'(eye_found), 32'd1);
`ifndef EYE_BOX_AVG_EN
            check("roi_high", 32'(eye_high), (f == 0) ? 32'd1 : 32'd2);
            check("roi_wide", 32'(eye_wide), (f == 0) ? 32'd20 : 32'd30);
`endif
            idle(2);
        end
        set_roi(100, 199, 50, 99);

        // Reset mid-frame: outputs clear at once, the interrupted frame never completes
        sof(1'b0);
        for (int x = 120; x < 150; x++) step(1'b1, x, 60, 1'b1);
        do_reset();
        for (int x = 120; x < 150; x++) step(1'b1, x, 61, 1'b1);
        eof(1'b0);
        idle(1);
        check("rst_no_done", 32'(frame_done), 32'd0);
        idle(2);
        sof(1'b0);
        scan_box(120, 159, 60, 79);
        eof(1'b0);
        idle(1);
        check("post_rst_done", 32'(frame_done), 32'd1);
`ifdef EYE_BOX_AVG_EN
        check("post_rst_high", 32'(eye_high), 32'd10);
        check("post_rst_wide", 32'(eye_wide), 32'd20);
`else
        check("post_rst_high", 32'(eye_high), 32'd20);
        check("post_rst_wide", 32'(eye_wide), 32'd40);
`endif

        // SOF in the latch cycle: that frame is skipped
        sof(1'b0);
        scan_box(130, 160, 70, 80);
        eof(1'b0);
        sof(1'b1);
        for (int x = 100; x < 140; x++) step(1'b1, x, 90, 1'b1);
        eof(1'b0);
        idle(1);
        check("skip_no_done", 32'(frame_done), 32'd0);
        idle(2);

        // Truncated frame restarted by a second SOF: only the complete frame counts
        sof(1'b0);
        scan_box(120, 159, 60, 79);
        sof(1'b0);
        for (int y = 90; y < 95; y++)
            for (int x = 180; x < 190; x++) step(1'b1, x, y, 1'b1);
        eof(1'b0);
        idle(1);
        check("trunc_done", 32'(frame_done), 32'd1);
`ifndef EYE_BOX_AVG_EN
        check("trunc_high", 32'(eye_high), 32'd5);
        check("trunc_wide", 32'(eye_wide), 32'd10);
`endif
        idle(2);

        // Randomized frames
        for (int f = 0; f < 60; f++) rand_frame();
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
